enc_bundler_accum: RTL

Downstream stage of the per-cycle binder pack. Consumes FEATURES_PER_CC shifted hypervectors per beat over NUM_CHUNKS beats and accumulates per-dimension saturating counts. It then thresholds the counts into one sparse query hypervector and presents it on a valid/ready output to the associative-search stage.

---
 rtl/enc_bundler_accum_pkg.sv | 28 ++
 rtl/enc_bundler_accum_if.sv | 25 ++
 rtl/enc_bundler_accum_bit_counter.sv | 47 ++++
 rtl/enc_bundler_accum.sv | 131 +++++++++++++
 4 files changed

// File: rtl/enc_bundler_accum_pkg.sv
// Shared parameters, derived widths and FSM state type for the encoder bundling stage.
package hdc_pkg;

  localparam int HV_DIM          = 1024;
  localparam int FEATURES_PER_CC = 4;
  localparam int NUM_CHUNKS      = 32;
  localparam int CNT_W           = 8;

  function automatic int sum_width(input int features);
    return $clog2(features + 1);
  endfunction

  // A single-beat encoding still needs a 1-bit chunk counter
  function automatic int chunk_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

  localparam int SUM_W   = sum_width(FEATURES_PER_CC);
  localparam int CHUNK_W = chunk_width(NUM_CHUNKS);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    THRESH,
    DONE
  } enc_bundle_state_t;

endpackage

// File: rtl/enc_bundler_accum_if.sv
// Beat input and query output handshake bundle of the bundling stage.
// With ENC_BUNDLE_DENSITY_EN defined the query also carries its popcount.
interface enc_bundler_accum_if #(
  parameter int DIM = hdc_pkg::HV_DIM,
  parameter int FPC = hdc_pkg::FEATURES_PER_CC
);
  logic           in_valid;
  logic [DIM-1:0] shifted_hv [FPC];
  logic           query_valid;
  logic           query_ready;
  logic [DIM-1:0] query_hv;
`ifdef ENC_BUNDLE_DENSITY_EN
  logic [$clog2(DIM+1)-1:0] query_density;

  modport master (output in_valid, shifted_hv, query_ready,
                  input  query_valid, query_hv, query_density);
  modport slave  (input  in_valid, shifted_hv, query_ready,
                  output query_valid, query_hv, query_density);
`else
  modport master (output in_valid, shifted_hv, query_ready,
                  input  query_valid, query_hv);
  modport slave  (input  in_valid, shifted_hv, query_ready,
                  output query_valid, query_hv);
`endif
endinterface

// File: rtl/enc_bundler_accum_bit_counter.sv
// One hypervector dimension: per-beat popcount, saturating accumulator and threshold compare.
module enc_bit_counter
  import hdc_pkg::*;
#(
  parameter int FPC = FEATURES_PER_CC,
  parameter int CW  = CNT_W
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clear,
  input  logic          en,
  input  logic [FPC-1:0] bits,
  input  logic [CW-1:0] thr,
  output logic          hit
);

  localparam int SW = sum_width(FPC);

  logic [SW-1:0] pop;
  logic [CW:0]   sum_ext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    pop = '0;
    for (int i = 0; i < FPC; i++) begin
      pop = pop + SW'(bits[i]);
    end
  end

  // The extra top bit of sum_ext is the overflow flag that triggers the clamp
  always_comb begin
    sum_ext  = {1'b0, cnt} + (CW+1)'(pop);
    cnt_next = sum_ext[CW] ? '1 : sum_ext[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_next;
    end
  end

  assign hit = (cnt >= thr);

endmodule

// File: rtl/enc_bundler_accum.sv
// Bundles NUM_CHUNKS beats of bound HVs into per-dimension counts and thresholds them into a query HV.
// Optional ENC_BUNDLE_DENSITY_EN adds query_density, the popcount of query_hv.
module enc_bundler_accum
  import hdc_pkg::*;
#(
  parameter int DIM    = HV_DIM,
  parameter int FPC    = FEATURES_PER_CC,
  parameter int CHUNKS = NUM_CHUNKS,
  parameter int CW     = CNT_W
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start_encoding,
  input  logic [CW-1:0]       threshold,
  output logic                busy,
  enc_bundler_accum_if.slave  bus
);

  localparam int CHW = chunk_width(CHUNKS);

  enc_bundle_state_t state, state_next;
  logic [CHW-1:0]    chunk_cnt;
  logic [CW-1:0]     thr_q;
  logic [DIM-1:0]    hit;
  logic              clear_cnt;
  logic              acc_en;
  logic              load_query;
  logic              last_beat;

  assign last_beat = (chunk_cnt == CHW'(CHUNKS - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    clear_cnt  = 1'b0;
    acc_en     = 1'b0;
    load_query = 1'b0;
    case (state)
      IDLE: begin
        if (start_encoding) begin
          clear_cnt  = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_en = 1'b1;
          if (last_beat) state_next = THRESH;
        end
      end
      THRESH: begin
        load_query = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (bus.query_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      chunk_cnt <= '0;
      thr_q     <= '0;
    end else if (clear_cnt) begin
      chunk_cnt <= '0;
      thr_q     <= threshold;
    end else if (acc_en) begin
      chunk_cnt <= chunk_cnt + CHW'(1);
    end
  end

  // Transpose the beat so each dimension's counter sees its FPC feature bits
  for (genvar b = 0; b < DIM; b++) begin : g_dim
    logic [FPC-1:0] col;

    always_comb begin
      col = '0;
      for (int i = 0; i < FPC; i++) begin
        col[i] = bus.shifted_hv[i][b];
      end
    end

    enc_bit_counter #(.FPC(FPC), .CW(CW)) u_bit_counter (
      .clk   (clk),
      .nrst  (nrst),
      .clear (clear_cnt),
      .en    (acc_en),
      .bits  (col),
      .thr   (thr_q),
      .hit   (hit[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      bus.query_hv    <= '0;
      bus.query_valid <= 1'b0;
    end else if (load_query) begin
      bus.query_hv    <= hit;
      bus.query_valid <= 1'b1;
    end else if (state == DONE && bus.query_ready) begin
      bus.query_valid <= 1'b0;
    end
  end

`ifdef ENC_BUNDLE_DENSITY_EN
  localparam int DW = $clog2(DIM + 1);

  logic [DW-1:0] density_next;

  always_comb begin
    density_next = '0;
    for (int b = 0; b < DIM; b++) begin
      density_next = density_next + DW'(hit[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst)           bus.query_density <= '0;
    else if (load_query) bus.query_density <= density_next;
  end
`endif

endmodule
